// File: rtl/systolic_drain.sv
// systolic_drain: double-buffered capture of N x N PE results,
// streamed out as row-major words of the M x M result matrix.
module systolic_drain #(
  parameter  int D_W_ACC = 16,
  parameter  int N       = 3,
  parameter  int M       = 6,
  localparam int T       = (M/N)*(M/N),
  localparam int AW      = $clog2(M*M),
  localparam int TW      = $clog2(T+1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [D_W_ACC*N*N-1:0] D,
  input  logic [N*N-1:0]         valid_D,
  output logic [D_W_ACC-1:0]     out_data,
  output logic [AW-1:0]          out_addr,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [TW-1:0]          tile_cnt,
  output logic                   done,
  output logic                   overflow
);

  localparam int NN  = N*N;
  localparam int IW  = $clog2(NN);
  localparam int TPR = M/N;

  typedef enum logic {IDLE = 1'b0, DRAIN = 1'b1} state_e;

  state_e                   state_q, state_d;
  logic [IW-1:0]            idx_q, idx_d;
  logic                     rd_bank_q, rd_bank_d;
  logic                     wr_bank_q, wr_bank_d;
  logic [1:0]               full_q, full_d;
  logic [TW-1:0]            tile_cnt_q, tile_cnt_d;
  logic                     done_q, done_d;
  logic                     ovf_q, ovf_d;
  logic [NN-1:0]            vld_q, vld_d;
  logic [D_W_ACC*NN-1:0]    dat_q, dat_d;
  logic [D_W_ACC-1:0]       bank_q [2][NN];
  logic [D_W_ACC-1:0]       bank_d [2][NN];
  logic                     cap_ok, set_full, clr_full;
  logic [31:0]              tr_w, tc_w, x_w, y_w;

  // Inputs are registered once so capture and drain see stable words.
  assign vld_d = valid_D;
  assign dat_d = D;

  assign cap_ok   = !full_q[wr_bank_q] && !done_q;
  assign set_full = cap_ok && vld_q[NN-1];

  always_comb begin
    bank_d = bank_q;
    for (int k = 0; k < NN; k++) begin
      if (cap_ok && vld_q[k]) begin
        bank_d[wr_bank_q][k] = dat_q[D_W_ACC*k +: D_W_ACC];
      end
    end
  end

  always_comb begin
    ovf_d     = ovf_q | (!done_q && full_q[wr_bank_q] && |vld_q);
    wr_bank_d = wr_bank_q ^ set_full;
    full_d    = full_q;
    if (clr_full) full_d[rd_bank_q] = 1'b0;
    if (set_full) full_d[wr_bank_q] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      rd_bank_q  <= 1'b0;
      wr_bank_q  <= 1'b0;
      full_q     <= '0;
      tile_cnt_q <= '0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      vld_q      <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      rd_bank_q  <= rd_bank_d;
      wr_bank_q  <= wr_bank_d;
      full_q     <= full_d;
      tile_cnt_q <= tile_cnt_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
      vld_q      <= vld_d;
    end
  end

  always_ff @(posedge clk) begin
    bank_q <= bank_d;
    dat_q  <= dat_d;
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    rd_bank_d  = rd_bank_q;
    tile_cnt_d = tile_cnt_q;
    done_d     = done_q;
    clr_full   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (full_q[rd_bank_q] && !done_q) begin
          state_d = DRAIN;
          idx_d   = '0;
        end
      end
      DRAIN: begin
        if (out_ready) begin
          if (idx_q == IW'(NN-1)) begin
            clr_full   = 1'b1;
            rd_bank_d  = ~rd_bank_q;
            tile_cnt_d = tile_cnt_q + TW'(1);
            idx_d      = '0;
            if (tile_cnt_d == TW'(T)) begin
              done_d  = 1'b1;
              state_d = IDLE;
            end else if (full_q[~rd_bank_q]) begin
              state_d = DRAIN;
            end else begin
              state_d = IDLE;
            end
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
    endcase
  end

  always_comb begin
    tr_w      = 32'(tile_cnt_q) / TPR;
    tc_w      = 32'(tile_cnt_q) % TPR;
    x_w       = 32'(idx_q) / N;
    y_w       = 32'(idx_q) % N;
    out_valid = (state_q == DRAIN);
    out_data  = '0;
    out_addr  = '0;
    if (out_valid) begin
      out_data = bank_q[rd_bank_q][idx_q];
      out_addr = AW'((tr_w*N + x_w)*M + tc_w*N + y_w);
    end
  end

  assign tile_cnt = tile_cnt_q;
  assign done     = done_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_systolic_drain.sv
// tb_systolic_drain: directed checks of capture, drain order,
// backpressure, overflow, reset and post-done behaviour.
`timescale 1ns/1ps
module tb_systolic_drain;

  localparam int DW = 16;
  localparam int N  = 3;
  localparam int M  = 6;
  localparam int NN = 9;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [DW*NN-1:0]  D;
  logic [NN-1:0]     valid_D;
  logic [DW-1:0]     out_data;
  logic [5:0]        out_addr;
  logic              out_valid;
  logic              out_ready;
  logic [2:0]        tile_cnt;
  logic              done;
  logic              overflow;

  int checks   = 0;
  int failures = 0;
  int vcyc     = 0;
  int ea[$];
  int ed[$];
  int xa[$];
  int xd[$];

  always #5 clk = ~clk;

  systolic_drain #(.D_W_ACC(DW), .N(N), .M(M)) dut (
    .clk(clk), .rst(rst), .D(D), .valid_D(valid_D),
    .out_data(out_data), .out_addr(out_addr),
    .out_valid(out_valid), .out_ready(out_ready),
    .tile_cnt(tile_cnt), .done(done), .overflow(overflow)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Every presented word is compared with the next expected word.
  always @(negedge clk) begin
    if (rst && out_valid) begin
      vcyc++;
      if (xa.size() < ea.size()) begin
        check("word_addr", out_addr, ea[xa.size()]);
        check("word_data", out_data, ed[xa.size()]);
      end else begin
        check("extra_word", out_valid, 0);
      end
      if (out_ready) begin
        xa.push_back(out_addr);
        xd.push_back(out_data);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    ea.delete();
    ed.delete();
    xa.delete();
    xd.delete();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    clear_q();
    tick(2);
    rst = 1'b1;
    tick(1);
  endtask

  task automatic load_exp(input int t, input int base);
    for (int k = 0; k < NN; k++) begin
      int x;
      int y;
      x = k / N;
      y = k % N;
      ea.push_back(((t/2)*N + x)*M + (t%2)*N + y);
      ed.push_back(base + 10*x + y);
    end
  endtask

  // Skewed arrival: PE[x][y] fires in cycle x+y.
  task automatic drive_tile(input int base);
    for (int k = 0; k < NN; k++)
      D[DW*k +: DW] = DW'(base + 10*(k/N) + k%N);
    for (int c = 0; c < 5; c++) begin
      valid_D = '0;
      for (int k = 0; k < NN; k++)
        if ((k/N) + (k%N) == c) valid_D[k] = 1'b1;
      tick(1);
    end
    valid_D = '0;
  endtask

  task automatic wait_xfers(input int n, input int budget,
                            input string tag);
    int c;
    c = 0;
    while (xa.size() < n && c < budget) begin
      tick(1);
      c++;
    end
    check(tag, xa.size(), n);
  endtask

  initial begin
    logic [35:0] seen;
    int dup;
    int c;
    D         = '0;
    valid_D   = '0;
    out_ready = 1'b1;
    rst       = 1'b0;
    tick(2);
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_addr", out_addr, 0);
    check("rst_tile_cnt", tile_cnt, 0);
    check("rst_done", done, 0);
    check("rst_ovf", overflow, 0);
    rst = 1'b1;
    tick(1);

    // single tile, latency and hand-computed order
    ea = '{0, 1, 2, 6, 7, 8, 12, 13, 14};
    ed = '{0, 1, 2, 10, 11, 12, 20, 21, 22};
    drive_tile(0);
    check("lat_e0", out_valid, 0);
    tick(1);
    check("lat_e1", out_valid, 0);
    tick(1);
    check("lat_e2", out_valid, 1);
    wait_xfers(9, 40, "t1_count");
    tick(2);
    check("t1_tile_cnt", tile_cnt, 1);
    check("t1_idle", out_valid, 0);

    // full matrix
    do_reset();
    for (int t = 0; t < 4; t++) load_exp(t, 100*t);
    for (int t = 0; t < 4; t++) begin
      drive_tile(100*t);
      tick(7);
    end
    wait_xfers(36, 200, "fm_count");
    check("fm_done", done, 1);
    check("fm_ovf", overflow, 0);
    check("fm_tile_cnt", tile_cnt, 4);
    seen = '0;
    dup  = 0;
    foreach (xa[i]) begin
      if (seen[xa[i]]) dup++;
      seen[xa[i]] = 1'b1;
    end
    check("fm_cover", $countones(seen), 36);
    check("fm_dups", dup, 0);
    if (xa.size() == 36) begin
      check("fm_t1_first", xa[9], 3);
      check("fm_t1_last", xa[17], 17);
      check("fm_t3_start", xa[27], 21);
    end

    // valid_D after done is ignored
    drive_tile(500);
    for (int i = 0; i < 10; i++) begin
      check("pd_valid", out_valid, 0);
      tick(1);
    end
    check("pd_ovf", overflow, 0);
    check("pd_done", done, 1);
    check("pd_tile_cnt", tile_cnt, 4);

    // backpressure with out_ready alternating
    do_reset();
    out_ready = 1'b0;
    load_exp(0, 40);
    vcyc = 0;
    drive_tile(40);
    c = 0;
    while (!out_valid && c < 10) begin
      tick(1);
      c++;
    end
    check("bp_start", out_valid, 1);
    for (int i = 0; i < 20; i++) begin
      out_ready = (i % 2 == 1);
      tick(1);
    end
    out_ready = 1'b1;
    check("bp_count", xa.size(), 9);
    check("bp_cycles", vcyc, 18);
    check("bp_tile_cnt", tile_cnt, 1);

    // overflow while both banks are held
    do_reset();
    out_ready = 1'b0;
    load_exp(0, 60);
    load_exp(1, 70);
    drive_tile(60);
    tick(3);
    drive_tile(70);
    tick(3);
    check("ov_before", overflow, 0);
    drive_tile(80);
    tick(2);
    check("ov_set", overflow, 1);
    out_ready = 1'b1;
    wait_xfers(18, 60, "ov_count");
    tick(5);
    check("ov_tile_cnt", tile_cnt, 2);
    check("ov_idle", out_valid, 0);
    check("ov_sticky", overflow, 1);

    // reset in the middle of a drain
    do_reset();
    load_exp(0, 90);
    drive_tile(90);
    wait_xfers(4, 20, "mr_pre");
    check("mr_busy", out_valid, 1);
    rst = 1'b0;
    #1;
    check("mr_valid", out_valid, 0);
    check("mr_data", out_data, 0);
    check("mr_addr", out_addr, 0);
    check("mr_tile_cnt", tile_cnt, 0);
    check("mr_done", done, 0);
    check("mr_ovf", overflow, 0);
    clear_q();
    tick(1);
    rst = 1'b1;
    load_exp(0, 150);
    drive_tile(150);
    wait_xfers(9, 40, "mr_count");
    tick(1);
    check("mr_tile_cnt2", tile_cnt, 1);
    if (xa.size() > 0) check("mr_first_addr", xa[0], 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/systolic_drain.md
SYSTOLIC_DRAIN -- requirements
Module: systolic_drain

Interface
REQ-001 The block SHALL have these parameters:
- D_W_ACC, default 16: accumulator word width.
- N, default 3: systolic array dimension (N x N PEs).
- M, default 6: matrix dimension; M is a multiple of N.
- T = (M/N)^2: tiles per matrix.
- AW = clog2(M*M): address width.

REQ-002 The block SHALL have these ports, clock and reset first:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- D  in  D_W_ACC*N*N  PE accumulators; PE[x][y] at bits [D_W_ACC*(x*N+y+1)-1 : D_W_ACC*(x*N+y)].
- valid_D  in  N*N  bit x*N+y high for one cycle when PE[x][y] result is final.
- out_data  out  D_W_ACC  result word.
- out_addr  out  AW  row-major address of out_data in the MxM result matrix.
- out_valid  out  1  out_data/out_addr valid.
- out_ready  in  1  consumer accepts the word.
- tile_cnt  out  clog2(T+1)  tiles fully drained.
- done  out  1  all T tiles drained; sticky.
- overflow  out  1  sticky error: a result arrived with no free buffer.

Function
REQ-003 The block SHALL have two tile banks of N*N words each, with a full flag per bank, a write-bank pointer wr_bank, and a read-bank pointer rd_bank.
REQ-004 Capture:
- Each cycle, for every set bit valid_D[k], D word k SHALL be written to bank[wr_bank][k], provided bank wr_bank is not full and done=0.
- Multiple bits in the same cycle SHALL all be captured.
REQ-005 Tile completion: valid_D[N*N-1] sampled high with a capture allowed SHALL set full[wr_bank] and toggle wr_bank on the same edge.
REQ-006 Capture while blocked:
- Any valid_D bit high while full[wr_bank]=1 and done=0 SHALL set overflow and discard the word.
- This SHALL NOT change the bank contents or the full flags.
REQ-007 After done=1, valid_D SHALL be ignored: no capture, and overflow is not set.
REQ-008 The drain state machine SHALL have states IDLE and DRAIN.
- IDLE -> DRAIN when full[rd_bank]=1; word index idx <= 0.
- out_valid SHALL be 1 exactly when in DRAIN, and SHALL be a registered output.
REQ-009 In DRAIN, out_data SHALL equal bank[rd_bank][idx].
REQ-010 In DRAIN, out_addr SHALL equal (tr*N + x)*M + (tc*N + y), where:
- x = idx/N, y = idx%N;
- tr = tile_cnt/(M/N), tc = tile_cnt%(M/N).
REQ-011 Transfer rule:
- A transfer occurs on an edge where out_valid=1 and out_ready=1; idx then increments.
- While out_valid=1 and out_ready=0, out_data and out_addr SHALL hold stable.
REQ-012 On the transfer with idx=N*N-1, on the same edge:
- clear full[rd_bank], toggle rd_bank, increment tile_cnt;
- if the other bank is full, stay in DRAIN with idx <= 0; otherwise go to IDLE.
REQ-013 done SHALL assert on the edge where tile_cnt becomes T. In DRAIN, out_valid SHALL then deassert, and the FSM SHALL return to IDLE and stay there.
REQ-014 Latency: out_valid SHALL rise exactly 2 edges after the edge that samples valid_D[N*N-1] high, when the drain FSM is IDLE. The throughput is one word per cycle with out_ready held high.
REQ-015 If one edge both clears full on one bank (drain end) and sets full on the other bank (capture), both updates SHALL take effect.
REQ-016 Tile ordering SHALL be the arrival order; bank contents SHALL never be reordered.

Reset
REQ-017 rst=0 SHALL asynchronously force:
- out_valid=0, out_data=0, out_addr=0;
- tile_cnt=0, done=0, overflow=0;
- both full flags=0, wr_bank=0, rd_bank=0, idx=0;
- FSM=IDLE.
REQ-018 Bank data SHALL NOT need a reset.
REQ-019 Reset asserted mid-drain or mid-capture SHALL abandon the partial tile. After reset release, the first completed tile SHALL be treated as tile 0.

Verification (N=3, M=6, D_W_ACC=16, T=4)
REQ-020 Single tile with skewed valid_D:
- Stimulus: PE[x][y]=10*x+y, valid bit asserted at cycle x+y, out_ready=1.
- Required: 9 words 0,1,2,10,11,12,20,21,22 at addrs 0,1,2,6,7,8,12,13,14.
- Required: out_valid rises 2 edges after valid_D[8]; tile_cnt=1.
REQ-021 Full matrix, 4 tiles back to back with out_ready=1:
- Required: 36 words with addrs covering 0..35 exactly once.
- Tile 1 words at cols 3..5 of rows 0..2; tile 3 starts at addr 21.
- Required: done=1 after the 36th transfer; overflow=0.
REQ-022 Backpressure:
- Stimulus: out_ready toggled 0/1 every cycle during a tile.
- Required: out_data/out_addr stable while stalled; no word lost or duplicated; 18 cycles to drain 9 words.
REQ-023 Overflow:
- Stimulus: out_ready=0 while 3 tiles complete.
- Required: the 3rd tile's valid_D sets overflow=1, and the first 2 tiles drain intact once out_ready=1.
REQ-024 Mid-drain reset:
- Stimulus: rst=0 pulsed after 4 transfers of tile 0.
- Required: all outputs 0 immediately (asynchronously); the next tile drains from addr 0 with tile_cnt starting at 0.
REQ-025 Post-done:
- Stimulus: valid_D pulses after done=1.
- Required: no out_valid; overflow stays 0; done stays 1.
